// File: rtl/cordic_atan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cordic_atan_pkg                                              |
// | Description : Shared widths, FSM encoding and the CORDIC arctan table      |
// |               (atan(2^-i) in degrees, Q8.32) for atan_cordic_sched.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cordic_atan_pkg;

  localparam int W_IN     = 32;
  localparam int GUARD    = 8;
  localparam int W_INT    = W_IN + GUARD;
  localparam int ITER_MAX = 38;
  localparam int ITER_W   = 6;

  // 180/pi scaled by 2^36: degrees-per-radian in Q32 plus four extra fraction bits
  localparam logic [127:0] DEG_PER_RAD_Q36 = 128'd3937335987320;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef logic [ITER_MAX-1:0][W_INT-1:0] atan_tab_t;

  // atan(2^-i) in Q8.32 degrees; Taylor series in Q64 radians, evaluated at elaboration
  function automatic logic [W_INT-1:0] atan_deg(input int i);
    logic [127:0] acc;
    logic [127:0] term;
    int           e;
    if (i == 0) return 40'h2D_0000_0000;
    acc = '0;
    for (int k = 0; k < 33; k++) begin
      e = 64 - i * (2 * k + 1);
      if (e >= 0) begin
        term = (128'd1 << e) / 128'(2 * k + 1);
        acc  = ((k % 2) == 0) ? acc + term : acc - term;
      end
    end
    return W_INT'((acc * DEG_PER_RAD_Q36 + (128'd1 << 67)) >> 68);
  endfunction

  function automatic atan_tab_t atan_table();
    atan_tab_t t;
    for (int i = 0; i < ITER_MAX; i++) t[i] = atan_deg(i);
    return t;
  endfunction

  localparam atan_tab_t ATAN = atan_table();

endpackage
`default_nettype wire

// File: rtl/cordic_atan_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cordic_atan_iter                                             |
// | Description : One vectoring-mode CORDIC micro-rotation (combinational).    |
// |               Drives y toward zero and accumulates the rotated angle in z. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cordic_atan_iter
  import cordic_atan_pkg::*;
(
  input  logic signed [W_INT-1:0]  i_x,
  input  logic signed [W_INT-1:0]  i_y,
  input  logic        [W_INT-1:0]  i_z,
  input  logic        [ITER_W-1:0] i_iter,
  output logic signed [W_INT-1:0]  o_x,
  output logic signed [W_INT-1:0]  o_y,
  output logic        [W_INT-1:0]  o_z
);

  logic signed [W_INT-1:0] w_sx;
  logic signed [W_INT-1:0] w_sy;
  logic        [W_INT-1:0] w_atan;

  assign w_sx   = i_x >>> i_iter;
  assign w_sy   = i_y >>> i_iter;
  assign w_atan = ATAN[i_iter];

  // Rotate against the sign of y; a y of exactly zero is already converged
  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    if (i_y > 0) begin
      o_x = i_x + w_sy;
      o_y = i_y - w_sx;
      o_z = i_z + w_atan;
    end else if (i_y < 0) begin
      o_x = i_x - w_sy;
      o_y = i_y + w_sx;
      o_z = i_z - w_atan;
    end
  end

endmodule
`default_nettype wire

// File: rtl/atan_cordic_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : atan_cordic_sched                                            |
// | Description : Time-shared iterative arctan engine. Two requesters share    |
// |               one CORDIC micro-rotation stage under round-robin grant;     |
// |               result is tagged with the owning requester id.               |
// |               Build option ATAN_ROUND_EN: round the Q8.24 result half up   |
// |               instead of truncating the guard bits.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module atan_cordic_sched
  import cordic_atan_pkg::*;
#(
  parameter int ITER = ITER_MAX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in0_valid,
  output logic            in0_ready,
  input  logic [W_IN-1:0] in0_x,
  input  logic [W_IN-1:0] in0_y,
  input  logic            in1_valid,
  output logic            in1_ready,
  input  logic [W_IN-1:0] in1_x,
  input  logic [W_IN-1:0] in1_y,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_id,
  output logic [W_IN-1:0] res_angle,
  output logic            busy
);

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITER - 1);

  state_t                  r_state;
  logic                    r_rr_ptr;
  logic                    r_id;
  logic [ITER_W-1:0]       r_iter;
  logic signed [W_INT-1:0] r_x;
  logic signed [W_INT-1:0] r_y;
  logic [W_INT-1:0]        r_z;
  logic                    r_res_valid;
  logic                    r_res_id;
  logic [W_IN-1:0]         r_res_angle;
  logic                    r_busy;

  logic                    w_idle;
  logic                    w_any;
  logic                    w_gnt;
  logic [W_IN-1:0]         w_sel_x;
  logic [W_IN-1:0]         w_sel_y;
  logic signed [W_INT-1:0] w_x_nx;
  logic signed [W_INT-1:0] w_y_nx;
  logic [W_INT-1:0]        w_z_nx;
  logic [W_IN-1:0]         w_angle;

  // Grant goes to the pointed-at requester when it is valid, otherwise to the other one
  assign w_idle    = (r_state == S_IDLE) && !rst;
  assign w_any     = in0_valid | in1_valid;
  assign w_gnt     = r_rr_ptr ? in1_valid : ~in0_valid;
  assign in0_ready = w_idle & w_any & ~w_gnt;
  assign in1_ready = w_idle & w_any &  w_gnt;
  assign w_sel_x   = w_gnt ? in1_x : in0_x;
  assign w_sel_y   = w_gnt ? in1_y : in0_y;

  cordic_atan_iter u_iter (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_z    (r_z),
    .i_iter (r_iter),
    .o_x    (w_x_nx),
    .o_y    (w_y_nx),
    .o_z    (w_z_nx)
  );

`ifdef ATAN_ROUND_EN
  assign w_angle = w_z_nx[W_INT-1:GUARD] + {{(W_IN-1){1'b0}}, w_z_nx[GUARD-1]};
`else
  assign w_angle = w_z_nx[W_INT-1:GUARD];
`endif

  // Control FSM plus datapath registers; the result is captured on the last rotation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 1'b0;
      r_id        <= 1'b0;
      r_iter      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_angle <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_x     <= {{GUARD{w_sel_x[W_IN-1]}}, w_sel_x};
            r_y     <= {{GUARD{w_sel_y[W_IN-1]}}, w_sel_y};
            r_z     <= '0;
            r_iter  <= '0;
            r_id    <= w_gnt;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_x    <= w_x_nx;
          r_y    <= w_y_nx;
          r_z    <= w_z_nx;
          r_iter <= r_iter + 1'b1;
          if (r_iter == ITER_LAST) begin
            r_res_valid <= 1'b1;
            r_res_angle <= w_angle;
            r_res_id    <= r_id;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_rr_ptr    <= ~r_id;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_angle = r_res_angle;
  assign busy      = r_busy;

endmodule
`default_nettype wire
